fetch_stage: RTL and testbench

//   Fetch stage plus IF/ID pipeline register for the 5-stage RV32I core.
//   - Owns PCF; drives a synchronous instruction memory (1-cycle read latency).
//   - Presents InstrD/PCD/PCPlus4D to decode.
//   - Obeys StallF/StallD/FlushD/PCSrcE from the hazard unit.
//   - A hold register keeps the decode instruction stable across stalls.
//

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard controls, instruction-memory port and IF/ID outputs.
// master = fetch stage, slave = hazard unit / imem / decode side.
interface fetch_stage_if;
    localparam int unsigned XLEN = 32;

    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            PCSrcE;
    logic [XLEN-1:0] PCTargetE;
    logic [XLEN-1:0] ImemAddr;
    logic            ImemRdEn;
    logic [XLEN-1:0] ImemRdata;
    logic [XLEN-1:0] InstrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCPlus4D;
    logic            ValidD;
    logic            MisalignErr;

    modport master (
        input  StallF, StallD, FlushD, PCSrcE, PCTargetE, ImemRdata,
        output ImemAddr, ImemRdEn, InstrD, PCD, PCPlus4D, ValidD, MisalignErr
    );

    modport slave (
        output StallF, StallD, FlushD, PCSrcE, PCTargetE, ImemRdata,
        input  ImemAddr, ImemRdEn, InstrD, PCD, PCPlus4D, ValidD, MisalignErr
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage + IF/ID register with a hold register for decode stalls.
// Optional FETCH_ALIGN_CHECK_EN: force-align redirect targets and flag misaligned ones.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LIVE  = 2'd1,
        HELD  = 2'd2
    } dec_state_e;

    dec_state_e      state;
    dec_state_e      state_nxt;
    logic [XLEN-1:0] pcf;
    logic [XLEN-1:0] pcf_nxt;
    logic [XLEN-1:0] pcd;
    logic [XLEN-1:0] pcplus4d;
    logic [XLEN-1:0] hold;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] instr_sel;
    logic            valid;
    logic            valid_nxt;
    logic            id_load;
    logic            hold_load;
    logic            misalign;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target = {bus.PCTargetE[XLEN-1:2], 2'b00};

    // Sticky until reset: any redirect to a non-word-aligned target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign <= 1'b0;
        end else if (bus.PCSrcE && (bus.PCTargetE[1:0] != 2'b00)) begin
            misalign <= 1'b1;
        end
    end
`else
    assign target   = bus.PCTargetE;
    assign misalign = 1'b0;
`endif

    // Redirect wins over StallF.
    always_comb begin
        pcf_nxt = pcf;
        if (bus.PCSrcE) begin
            pcf_nxt = target;
        end else if (!bus.StallF) begin
            pcf_nxt = pcf + XLEN'(4);
        end
    end

    // Decode FSM: flush > stall > bubble > advance.
    always_comb begin
        state_nxt = state;
        valid_nxt = valid;
        id_load   = 1'b0;
        hold_load = 1'b0;
        if (bus.FlushD) begin
            state_nxt = EMPTY;
            valid_nxt = 1'b0;
        end else if (bus.StallD) begin
            if (state == LIVE) begin
                state_nxt = HELD;
                hold_load = 1'b1;
            end
        end else if (bus.StallF) begin
            state_nxt = EMPTY;
            valid_nxt = 1'b0;
        end else begin
            state_nxt = LIVE;
            valid_nxt = 1'b1;
            id_load   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcf      <= RESET_VECTOR;
            pcd      <= '0;
            pcplus4d <= '0;
            valid    <= 1'b0;
            hold     <= NOP_INSTR;
        end else begin
            pcf   <= pcf_nxt;
            valid <= valid_nxt;
            if (id_load) begin
                pcd      <= pcf;
                pcplus4d <= pcf + XLEN'(4);
            end
            if (hold_load) begin
                hold <= bus.ImemRdata;
            end
        end
    end

    // Memory data is only trusted in LIVE; a stall parks it in hold.
    always_comb begin
        instr_sel = NOP_INSTR;
        if (valid) begin
            case (state)
                LIVE:    instr_sel = bus.ImemRdata;
                HELD:    instr_sel = hold;
                default: instr_sel = NOP_INSTR;
            endcase
        end
    end

    assign bus.ImemAddr    = pcf;
    assign bus.ImemRdEn    = !bus.StallF || bus.PCSrcE;
    assign bus.InstrD      = instr_sel;
    assign bus.PCD         = pcd;
    assign bus.PCPlus4D    = pcplus4d;
    assign bus.ValidD      = valid;
    assign bus.MisalignErr = misalign;
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: vector table applied per cycle, expected
// results queued at drive time and popped after the clock edge.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic ALN = 1'b1;
`else
    localparam logic ALN = 1'b0;
`endif
    localparam int NV = 32;

    typedef struct {
        logic        sf, sd, fd, br;
        logic [31:0] tgt;
        logic [31:0] pcf, pcd, instr;
        logic        valid, mis;
    } vec_t;

    typedef struct {
        logic [31:0] pcf, pcd, pcp4, instr;
        logic        valid, mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rdata_q = 32'h0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    vec_t        tbl[NV];

    fetch_stage_if bus();

    fetch_stage dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // imem[i] = i; read data is garbage whenever the read is not enabled.
    always @(posedge clk) begin
        rdata_q <= bus.ImemRdEn ? {2'b00, bus.ImemAddr[31:2]} : 32'hDEAD_BEEF;
    end
    assign bus.ImemRdata = rdata_q;

    function automatic vec_t mkv(input logic sf, sd, fd, br, input logic [31:0] tgt,
                                 input logic [31:0] pcf, pcd, instr, input logic valid, mis);
        vec_t v;
        v.sf = sf; v.sd = sd; v.fd = fd; v.br = br; v.tgt = tgt;
        v.pcf = pcf; v.pcd = pcd; v.instr = instr; v.valid = valid; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_imemaddr"}, bus.ImemAddr, 32'h0);
        chk({tag, "_pcd"}, bus.PCD, 32'h0);
        chk({tag, "_pcplus4d"}, bus.PCPlus4D, 32'h0);
        chk({tag, "_validd"}, 32'(bus.ValidD), 32'h0);
        chk({tag, "_instrd"}, bus.InstrD, NOP);
        chk({tag, "_misalign"}, 32'(bus.MisalignErr), 32'h0);
    endtask

    // Called with clk low; returns at the following negedge.
    task automatic step(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        bus.StallF = v.sf; bus.StallD = v.sd; bus.FlushD = v.fd;
        bus.PCSrcE = v.br; bus.PCTargetE = v.tgt;
        #1;
        chk($sformatf("v%0d_rden", idx), 32'(bus.ImemRdEn), 32'(!v.sf || v.br));
        e.pcf = v.pcf; e.pcd = v.pcd; e.pcp4 = v.pcd + 32'd4;
        e.instr = v.instr; e.valid = v.valid; e.mis = v.mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d_sb_empty", idx), 32'h1, 32'h0);
        end else begin
            got = sb.pop_front();
            chk($sformatf("v%0d_pcf", idx), bus.ImemAddr, got.pcf);
            chk($sformatf("v%0d_pcd", idx), bus.PCD, got.pcd);
            chk($sformatf("v%0d_pcplus4d", idx), bus.PCPlus4D, got.pcp4);
            chk($sformatf("v%0d_instrd", idx), bus.InstrD, got.instr);
            chk($sformatf("v%0d_validd", idx), 32'(bus.ValidD), 32'(got.valid));
            chk($sformatf("v%0d_misalign", idx), 32'(bus.MisalignErr), 32'(got.mis));
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] p;
        p = ALN ? 32'h100 : 32'h102;
        //                sf sd fd br tgt            pcf            pcd            instr          v  mis
        tbl[0]  = mkv(0, 0, 0, 0, 32'h0,         32'h4,         32'h0,         32'h0,         1, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 32'h0,         32'h8,         32'h4,         32'h1,         1, 0);
        tbl[2]  = mkv(0, 0, 0, 0, 32'h0,         32'hC,         32'h8,         32'h2,         1, 0);
        tbl[3]  = mkv(1, 1, 0, 0, 32'h0,         32'hC,         32'h8,         32'h2,         1, 0);
        tbl[4]  = mkv(1, 1, 0, 0, 32'h0,         32'hC,         32'h8,         32'h2,         1, 0);
        tbl[5]  = mkv(1, 1, 0, 0, 32'h0,         32'hC,         32'h8,         32'h2,         1, 0);
        tbl[6]  = mkv(0, 0, 0, 0, 32'h0,         32'h10,        32'hC,         32'h3,         1, 0);
        tbl[7]  = mkv(0, 0, 0, 0, 32'h0,         32'h14,        32'h10,        32'h4,         1, 0);
        tbl[8]  = mkv(1, 0, 0, 0, 32'h0,         32'h14,        32'h10,        NOP,           0, 0);
        tbl[9]  = mkv(0, 0, 0, 0, 32'h0,         32'h18,        32'h14,        32'h5,         1, 0);
        tbl[10] = mkv(0, 0, 1, 1, 32'h100,       32'h100,       32'h14,        NOP,           0, 0);
        tbl[11] = mkv(0, 0, 0, 0, 32'h0,         32'h104,       32'h100,       32'h40,        1, 0);
        tbl[12] = mkv(0, 0, 0, 0, 32'h0,         32'h108,       32'h104,       32'h41,        1, 0);
        tbl[13] = mkv(1, 1, 0, 1, 32'h100,       32'h100,       32'h104,       32'h41,        1, 0);
        tbl[14] = mkv(0, 0, 1, 0, 32'h0,         32'h104,       32'h104,       NOP,           0, 0);
        tbl[15] = mkv(0, 0, 0, 0, 32'h0,         32'h108,       32'h104,       32'h41,        1, 0);
        tbl[16] = mkv(1, 1, 1, 0, 32'h0,         32'h108,       32'h104,       NOP,           0, 0);
        tbl[17] = mkv(0, 0, 0, 0, 32'h0,         32'h10C,       32'h108,       32'h42,        1, 0);
        tbl[18] = mkv(1, 0, 0, 0, 32'h0,         32'h10C,       32'h108,       NOP,           0, 0);
        tbl[19] = mkv(1, 1, 0, 0, 32'h0,         32'h10C,       32'h108,       NOP,           0, 0);
        tbl[20] = mkv(0, 0, 0, 0, 32'h0,         32'h110,       32'h10C,       32'h43,        1, 0);
        tbl[21] = mkv(0, 0, 1, 1, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'h10C,       NOP,           0, 0);
        tbl[22] = mkv(0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h3FFF_FFFE, 1, 0);
        tbl[23] = mkv(0, 0, 0, 0, 32'h0,         32'h0,         32'hFFFF_FFFC, 32'h3FFF_FFFF, 1, 0);
        tbl[24] = mkv(0, 0, 0, 0, 32'h0,         32'h4,         32'h0,         32'h0,         1, 0);
        tbl[25] = mkv(0, 0, 1, 1, 32'h102,       p,             32'h0,         NOP,           0, ALN);
        tbl[26] = mkv(0, 0, 0, 0, 32'h0,         p + 32'd4,     p,             32'h40,        1, ALN);
        tbl[27] = mkv(0, 0, 0, 0, 32'h0,         p + 32'd8,     p + 32'd4,     32'h41,        1, ALN);
        tbl[28] = mkv(0, 0, 1, 1, 32'h0,         32'h0,         p + 32'd4,     NOP,           0, ALN);
        tbl[29] = mkv(0, 0, 0, 0, 32'h0,         32'h4,         32'h0,         32'h0,         1, ALN);
        tbl[30] = mkv(0, 0, 0, 0, 32'h0,         32'h8,         32'h4,         32'h1,         1, ALN);
        tbl[31] = mkv(1, 1, 0, 0, 32'h0,         32'h8,         32'h4,         32'h1,         1, ALN);

        bus.StallF = 1'b0; bus.StallD = 1'b0; bus.FlushD = 1'b0;
        bus.PCSrcE = 1'b0; bus.PCTargetE = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(tbl[i], i);
        end

        // Asynchronous reset mid-stall, asserted between clock edges.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(mkv(0, 0, 0, 0, 32'h0, 32'h4, 32'h0, 32'h0, 1, 0), 100);
        step(mkv(0, 0, 0, 0, 32'h0, 32'h8, 32'h4, 32'h1, 1, 0), 101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
